// File: rtl/axil_arbiter_if.sv
`timescale 1ns/1ps
// AXI4-Lite channel bundle; "master" drives requests, "slave" drives responses.
// Widths follow the instance parameters; one instance per port.
interface axil_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin AXI4-Lite arbiter, one transaction in flight, write before read.
// Latency: 1 cycle arbitration, then combinational forwarding; 1 cycle back to IDLE.
// Backpressure: ungranted master sees no ready; AXIL_ARB_TIMEOUT_EN adds an SLVERR watchdog.
module axil_arbiter #(
    parameter int AXI_AWIDTH = 12,
    parameter int AXI_DWIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    axil_arbiter_if.slave  m0,
    axil_arbiter_if.slave  m1,
    axil_arbiter_if.master s,
    output logic           grant,
    output logic           busy
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("TIMEOUT must be at least 2");
    end

    state_t                state, state_nx;
    logic                  grant_nx, last_grant, last_grant_nx;
    logic                  aw_done, w_done, aw_done_nx, w_done_nx;
    logic                  aw_now, w_now, pick, to_hit;
    logic                  wr0, wr1, req0, req1;
    logic                  g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic                  g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
    logic [1:0]            g_bresp, g_rresp;
    logic [AXI_DWIDTH-1:0] g_rdata;
    logic                  s_awvalid_c, s_wvalid_c, s_bready_c, s_arvalid_c, s_rready_c;
    logic [AXI_AWIDTH-1:0] aw_addr_mux, ar_addr_mux;

    assign wr0  = m0.awvalid & m0.wvalid;
    assign wr1  = m1.awvalid & m1.wvalid;
    assign req0 = wr0 | m0.arvalid;
    assign req1 = wr1 | m1.arvalid;

    assign g_awvalid = grant ? m1.awvalid : m0.awvalid;
    assign g_wvalid  = grant ? m1.wvalid  : m0.wvalid;
    assign g_bready  = grant ? m1.bready  : m0.bready;
    assign g_arvalid = grant ? m1.arvalid : m0.arvalid;
    assign g_rready  = grant ? m1.rready  : m0.rready;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] to_cnt;
    logic             to_flag;

    // Counter restarts on every state change so each phase gets the full budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state_nx != state) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (state != IDLE && !to_flag) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == CNT_W'(TIMEOUT - 1))
                to_flag <= 1'b1;
        end
    end
    assign to_hit = to_flag;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            aw_done    <= aw_done_nx;
            w_done     <= w_done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        aw_done_nx    = aw_done;
        w_done_nx     = w_done;
        aw_now        = 1'b0;
        w_now         = 1'b0;
        pick          = 1'b0;
        s_awvalid_c   = 1'b0;
        s_wvalid_c    = 1'b0;
        s_bready_c    = 1'b0;
        s_arvalid_c   = 1'b0;
        s_rready_c    = 1'b0;
        g_awready     = 1'b0;
        g_wready      = 1'b0;
        g_bvalid      = 1'b0;
        g_arready     = 1'b0;
        g_rvalid      = 1'b0;
        g_bresp       = s.bresp;
        g_rresp       = s.rresp;
        g_rdata       = s.rdata;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // Prefer the master that did not win last time.
                    pick          = last_grant ? !req0 : req1;
                    grant_nx      = pick;
                    last_grant_nx = pick;
                    state_nx      = (pick ? wr1 : wr0) ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ, WR_RESP: begin
                if (to_hit) begin
                    g_bvalid = 1'b1;
                    g_bresp  = 2'b10;
                    if (g_bready) begin
                        state_nx   = IDLE;
                        aw_done_nx = 1'b0;
                        w_done_nx  = 1'b0;
                    end
                end else if (state == WR_REQ) begin
                    s_awvalid_c = g_awvalid & ~aw_done;
                    g_awready   = s.awready & ~aw_done;
                    s_wvalid_c  = g_wvalid & ~w_done;
                    g_wready    = s.wready & ~w_done;
                    aw_now      = aw_done | (s_awvalid_c & s.awready);
                    w_now       = w_done | (s_wvalid_c & s.wready);
                    if (aw_now & w_now) begin
                        state_nx   = WR_RESP;
                        aw_done_nx = 1'b0;
                        w_done_nx  = 1'b0;
                    end else begin
                        aw_done_nx = aw_now;
                        w_done_nx  = w_now;
                    end
                end else begin
                    s_bready_c = g_bready;
                    g_bvalid   = s.bvalid;
                    if (s.bvalid & g_bready)
                        state_nx = IDLE;
                end
            end
            RD_REQ, RD_RESP: begin
                if (to_hit) begin
                    g_rvalid = 1'b1;
                    g_rresp  = 2'b10;
                    g_rdata  = '0;
                    if (g_rready)
                        state_nx = IDLE;
                end else if (state == RD_REQ) begin
                    s_arvalid_c = g_arvalid;
                    g_arready   = s.arready;
                    if (g_arvalid & s.arready)
                        state_nx = RD_RESP;
                end else begin
                    s_rready_c = g_rready;
                    g_rvalid   = s.rvalid;
                    if (s.rvalid & g_rready)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Payloads follow the registered grant, so they stay put while valid is low.
    assign aw_addr_mux = grant ? m1.awaddr : m0.awaddr;
    assign ar_addr_mux = grant ? m1.araddr : m0.araddr;
    assign s.awaddr    = aw_addr_mux;
    assign s.awprot    = grant ? m1.awprot : m0.awprot;
    assign s.wdata     = grant ? m1.wdata  : m0.wdata;
    assign s.wstrb     = grant ? m1.wstrb  : m0.wstrb;
    assign s.araddr    = ar_addr_mux;
    assign s.arprot    = grant ? m1.arprot : m0.arprot;
    assign s.awvalid   = s_awvalid_c;
    assign s.wvalid    = s_wvalid_c;
    assign s.bready    = s_bready_c;
    assign s.arvalid   = s_arvalid_c;
    assign s.rready    = s_rready_c;

    assign m0.awready = g_awready & ~grant;
    assign m0.wready  = g_wready  & ~grant;
    assign m0.bvalid  = g_bvalid  & ~grant;
    assign m0.arready = g_arready & ~grant;
    assign m0.rvalid  = g_rvalid  & ~grant;
    assign m1.awready = g_awready & grant;
    assign m1.wready  = g_wready  & grant;
    assign m1.bvalid  = g_bvalid  & grant;
    assign m1.arready = g_arready & grant;
    assign m1.rvalid  = g_rvalid  & grant;
    assign m0.bresp   = g_bresp;
    assign m1.bresp   = g_bresp;
    assign m0.rresp   = g_rresp;
    assign m1.rresp   = g_rresp;
    assign m0.rdata   = g_rdata;
    assign m1.rdata   = g_rdata;
endmodule

// File: tb/tb_axil_arbiter.sv
`timescale 1ns/1ps
// Directed bench for axil_arbiter: two scripted masters and a small slave model.
module tb_axil_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic grant, busy;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axil_arbiter_if #(.AW(12), .DW(32)) m0_if ();
    axil_arbiter_if #(.AW(12), .DW(32)) m1_if ();
    axil_arbiter_if #(.AW(12), .DW(32)) s_if ();

    axil_arbiter #(.AXI_AWIDTH(12), .AXI_DWIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
        .grant(grant), .busy(busy)
    );

    // Slave model: response registered one cycle after the request completes.
    logic        aw_rdy_en, w_rdy_en, ar_rdy_en, resp_en;
    logic [1:0]  slv_resp;
    logic        aw_got, w_got, bvalid_r, rvalid_r;
    logic [31:0] rdata_r, wr_data;
    logic [11:0] wr_addr;

    assign s_if.awready = aw_rdy_en;
    assign s_if.wready  = w_rdy_en;
    assign s_if.arready = ar_rdy_en;
    assign s_if.bvalid  = bvalid_r & resp_en;
    assign s_if.bresp   = slv_resp;
    assign s_if.rvalid  = rvalid_r & resp_en;
    assign s_if.rdata   = rdata_r;
    assign s_if.rresp   = slv_resp;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            if (s_if.awvalid && s_if.awready) begin
                aw_got  <= 1'b1;
                wr_addr <= s_if.awaddr;
            end
            if (s_if.wvalid && s_if.wready) begin
                w_got   <= 1'b1;
                wr_data <= s_if.wdata;
            end
            if ((aw_got || (s_if.awvalid && s_if.awready)) &&
                (w_got || (s_if.wvalid && s_if.wready))) begin
                bvalid_r <= 1'b1;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (s_if.bvalid && s_if.bready) bvalid_r <= 1'b0;
            if (s_if.arvalid && s_if.arready) begin
                rvalid_r <= 1'b1;
                rdata_r  <= 32'hA5A5_0000 | {20'h0, s_if.araddr};
            end
            if (s_if.rvalid && s_if.rready) rvalid_r <= 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.awvalid = 1'b0;
        m0_if.wdata  = '0; m0_if.wstrb  = '0; m0_if.wvalid  = 1'b0;
        m0_if.araddr = '0; m0_if.arprot = '0; m0_if.arvalid = 1'b0;
        m0_if.bready = 1'b1; m0_if.rready = 1'b1;
        m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.awvalid = 1'b0;
        m1_if.wdata  = '0; m1_if.wstrb  = '0; m1_if.wvalid  = 1'b0;
        m1_if.araddr = '0; m1_if.arprot = '0; m1_if.arvalid = 1'b0;
        m1_if.bready = 1'b1; m1_if.rready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_masters();
        aw_rdy_en = 1'b1; w_rdy_en = 1'b1; ar_rdy_en = 1'b1;
        resp_en = 1'b1; slv_resp = 2'b00;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    // Samples this cycle's handshakes, advances one clock, drops accepted valids.
    task automatic master_step(output logic b0, output logic b1, output logic r0,
                               output logic r1, output logic [31:0] rd0,
                               output logic [31:0] rd1);
        logic aw0, w0, ar0, aw1, w1, ar1;
        b0  = m0_if.bvalid & m0_if.bready;
        b1  = m1_if.bvalid & m1_if.bready;
        r0  = m0_if.rvalid & m0_if.rready;
        r1  = m1_if.rvalid & m1_if.rready;
        rd0 = m0_if.rdata;
        rd1 = m1_if.rdata;
        aw0 = m0_if.awvalid & m0_if.awready;
        w0  = m0_if.wvalid  & m0_if.wready;
        ar0 = m0_if.arvalid & m0_if.arready;
        aw1 = m1_if.awvalid & m1_if.awready;
        w1  = m1_if.wvalid  & m1_if.wready;
        ar1 = m1_if.arvalid & m1_if.arready;
        cyc();
        if (aw0) m0_if.awvalid = 1'b0;
        if (w0)  m0_if.wvalid  = 1'b0;
        if (ar0) m0_if.arvalid = 1'b0;
        if (aw1) m1_if.awvalid = 1'b0;
        if (w1)  m1_if.wvalid  = 1'b0;
        if (ar1) m1_if.arvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_masters();
        aw_rdy_en = 1'b1; w_rdy_en = 1'b1; ar_rdy_en = 1'b1;
        resp_en = 1'b1; slv_resp = 2'b00;
        m1_if.araddr = 12'h0AB; m1_if.arvalid = 1'b1;
        repeat (2) cyc();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0", grant); end
        n_cmp++;
        if ({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready} !== 5'b0) begin
            n_err++; $display("FAIL reset_s_hs: got %b want 00000",
                {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready});
        end
        n_cmp++;
        if ({m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid,
             m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready, m1_if.rvalid} !== 10'b0) begin
            n_err++; $display("FAIL reset_m_hs: upstream handshake outputs not all 0");
        end
        rst_n = 1'b1;
        cyc();
        // Only m1 pending: granted one cycle after leaving reset.
        n_cmp++; if (grant !== 1'b1) begin n_err++; $display("FAIL arb_grant_m1: got %b want 1", grant); end
        n_cmp++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 12'h0AB) begin
            n_err++; $display("FAIL arb_latency: arvalid %b araddr %h want 1 0ab", s_if.arvalid, s_if.araddr);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        m0_if.awaddr = 12'h010; m0_if.awvalid = 1'b1;
        m0_if.wdata = 32'hDEAD_BEEF; m0_if.wstrb = 4'hF; m0_if.wvalid = 1'b1;
        #1;
        n_cmp++; if (s_if.awvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL wr_c0: awvalid %b busy %b want 0 0", s_if.awvalid, busy);
        end
        cyc();
        n_cmp++; if (s_if.awvalid !== 1'b1 || s_if.awaddr !== 12'h010) begin
            n_err++; $display("FAIL wr_c1_aw: awvalid %b awaddr %h want 1 010", s_if.awvalid, s_if.awaddr);
        end
        n_cmp++; if (s_if.wvalid !== 1'b1 || s_if.wdata !== 32'hDEAD_BEEF || s_if.wstrb !== 4'hF) begin
            n_err++; $display("FAIL wr_c1_w: wvalid %b wdata %h wstrb %h want 1 deadbeef f",
                s_if.wvalid, s_if.wdata, s_if.wstrb);
        end
        n_cmp++; if ({m0_if.awready, m0_if.wready, m1_if.awready, s_if.arvalid} !== 4'b1100) begin
            n_err++; $display("FAIL wr_c1_rdy: got %b want 1100",
                {m0_if.awready, m0_if.wready, m1_if.awready, s_if.arvalid});
        end
        cyc();
        m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0;
        #1;
        n_cmp++; if (m0_if.bvalid !== 1'b1 || m0_if.bresp !== 2'b00 || busy !== 1'b1) begin
            n_err++; $display("FAIL wr_c2_b: bvalid %b bresp %b busy %b want 1 00 1",
                m0_if.bvalid, m0_if.bresp, busy);
        end
        cyc();
        n_cmp++; if (busy !== 1'b0 || m0_if.bvalid !== 1'b0) begin
            n_err++; $display("FAIL wr_c3_idle: busy %b bvalid %b want 0 0", busy, m0_if.bvalid);
        end
        n_cmp++; if (wr_addr !== 12'h010 || wr_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL wr_slave: addr %h data %h want 010 deadbeef", wr_addr, wr_data);
        end
    endtask

    task automatic test_round_robin();
        logic b0, b1, r0, r1;
        logic [31:0] rd0, rd1;
        logic [11:0] a0, a1;
        int done;
        do_reset();
        a0 = 12'h100; a1 = 12'h200; done = 0;
        m0_if.araddr = a0; m0_if.arvalid = 1'b1;
        m1_if.araddr = a1; m1_if.arvalid = 1'b1;
        #1;
        for (int i = 0; i < 60 && done < 4; i++) begin
            master_step(b0, b1, r0, r1, rd0, rd1);
            if (r0) begin
                n_cmp++; if ((done % 2) != 0 || rd0 !== (32'hA5A5_0000 | {20'h0, a0})) begin
                    n_err++; $display("FAIL rr_m0: slot %0d rdata %h want slot even rdata %h",
                        done, rd0, 32'hA5A5_0000 | {20'h0, a0});
                end
                done++; a0 = a0 + 12'h4;
                m0_if.araddr = a0; m0_if.arvalid = 1'b1;
            end
            if (r1) begin
                n_cmp++; if ((done % 2) != 1 || rd1 !== (32'hA5A5_0000 | {20'h0, a1})) begin
                    n_err++; $display("FAIL rr_m1: slot %0d rdata %h want slot odd rdata %h",
                        done, rd1, 32'hA5A5_0000 | {20'h0, a1});
                end
                done++; a1 = a1 + 12'h4;
                m1_if.araddr = a1; m1_if.arvalid = 1'b1;
            end
            #1;
        end
        n_cmp++; if (done != 4) begin n_err++; $display("FAIL rr_count: got %0d reads want 4", done); end
        do_reset();
    endtask

    task automatic test_wr_then_rd();
        logic b0, b1, r0, r1;
        logic [31:0] rd0, rd1;
        int b_at, r_at;
        do_reset();
        b_at = -1; r_at = -1;
        m0_if.awaddr = 12'h020; m0_if.awvalid = 1'b1;
        m0_if.wdata = 32'h1234_5678; m0_if.wstrb = 4'hF; m0_if.wvalid = 1'b1;
        m0_if.araddr = 12'h030; m0_if.arvalid = 1'b1;
        #1;
        master_step(b0, b1, r0, r1, rd0, rd1);
        n_cmp++; if ({s_if.awvalid, s_if.arvalid, grant} !== 3'b100) begin
            n_err++; $display("FAIL wr_first: aw/ar/grant %b want 100", {s_if.awvalid, s_if.arvalid, grant});
        end
        for (int i = 1; i < 30 && r_at < 0; i++) begin
            master_step(b0, b1, r0, r1, rd0, rd1);
            if (b0) b_at = i;
            if (r0) begin
                r_at = i;
                n_cmp++; if (rd0 !== 32'hA5A5_0030 || grant !== 1'b0) begin
                    n_err++; $display("FAIL wr_rd_data: rdata %h grant %b want a5a50030 0", rd0, grant);
                end
            end
        end
        n_cmp++; if (b_at != 2 || r_at != 5) begin
            n_err++; $display("FAIL wr_rd_order: b at %0d r at %0d want 2 5", b_at, r_at);
        end
        n_cmp++; if (wr_addr !== 12'h020 || wr_data !== 32'h1234_5678) begin
            n_err++; $display("FAIL wr_rd_slave: addr %h data %h want 020 12345678", wr_addr, wr_data);
        end
    endtask

    task automatic test_w_before_aw();
        logic b0, b1, r0, r1;
        logic [31:0] rd0, rd1;
        int wr_cnt, sw_cnt, saw_cnt;
        do_reset();
        aw_rdy_en = 1'b0;
        wr_cnt = 0; sw_cnt = 0; saw_cnt = 0;
        m0_if.awaddr = 12'h044; m0_if.awvalid = 1'b1;
        m0_if.wdata = 32'hCAFE_F00D; m0_if.wstrb = 4'h3; m0_if.wvalid = 1'b1;
        #1;
        master_step(b0, b1, r0, r1, rd0, rd1);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin aw_rdy_en = 1'b1; #1; end
            wr_cnt  += int'(m0_if.wready);
            sw_cnt  += int'(s_if.wvalid);
            saw_cnt += int'(s_if.awvalid);
            master_step(b0, b1, r0, r1, rd0, rd1);
        end
        n_cmp++; if (wr_cnt != 1) begin n_err++; $display("FAIL wfirst_wready: %0d pulses want 1", wr_cnt); end
        n_cmp++; if (sw_cnt != 1) begin n_err++; $display("FAIL wfirst_swvalid: %0d cycles want 1", sw_cnt); end
        n_cmp++; if (saw_cnt != 4) begin n_err++; $display("FAIL wfirst_hold: awvalid %0d cycles want 4", saw_cnt); end
        n_cmp++; if (m0_if.bvalid !== 1'b1 || wr_data !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL wfirst_b: bvalid %b data %h want 1 cafef00d", m0_if.bvalid, wr_data);
        end
    endtask

    task automatic test_reset_mid_read();
        logic b0, b1, r0, r1;
        logic [31:0] rd0, rd1;
        int got;
        do_reset();
        resp_en = 1'b0;
        m0_if.araddr = 12'h040; m0_if.arvalid = 1'b1;
        #1;
        master_step(b0, b1, r0, r1, rd0, rd1);
        master_step(b0, b1, r0, r1, rd0, rd1);
        n_cmp++; if ({busy, s_if.rready, m0_if.rvalid} !== 3'b110) begin
            n_err++; $display("FAIL rdresp_stall: busy/rready/rvalid %b want 110", {busy, s_if.rready, m0_if.rvalid});
        end
        rst_n = 1'b0;
        cyc();
        n_cmp++; if (busy !== 1'b0 || grant !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: busy %b grant %b want 0 0", busy, grant);
        end
        n_cmp++;
        if ({s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.rready, s_if.bready,
             m0_if.rvalid, m0_if.bvalid, m1_if.rvalid, m1_if.bvalid} !== 9'b0) begin
            n_err++; $display("FAIL midrst_valids: handshake outputs not all 0 after reset");
        end
        rst_n = 1'b1; resp_en = 1'b1; slv_resp = 2'b01;
        m1_if.araddr = 12'h050; m1_if.arvalid = 1'b1;
        #1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            if (m1_if.rvalid) begin
                got = 1;
                n_cmp++; if (m1_if.rdata !== 32'hA5A5_0050 || m1_if.rresp !== 2'b01 || grant !== 1'b1) begin
                    n_err++; $display("FAIL postrst_m1: rdata %h rresp %b grant %b want a5a50050 01 1",
                        m1_if.rdata, m1_if.rresp, grant);
                end
            end
            master_step(b0, b1, r0, r1, rd0, rd1);
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL postrst_timeout: got %0d responses want 1", got); end
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic b0, b1, r0, r1;
        logic [31:0] rd0, rd1;
        int first_at;
        do_reset();
        resp_en = 1'b0;
        first_at = -1;
        m0_if.awaddr = 12'h060; m0_if.awvalid = 1'b1;
        m0_if.wdata = 32'h1; m0_if.wstrb = 4'hF; m0_if.wvalid = 1'b1;
        #1;
        master_step(b0, b1, r0, r1, rd0, rd1);
        master_step(b0, b1, r0, r1, rd0, rd1);
        for (int k = 0; k < 24 && first_at < 0; k++) begin
            if (m0_if.bvalid) begin
                first_at = k;
                n_cmp++; if (m0_if.bresp !== 2'b10 || s_if.bready !== 1'b0) begin
                    n_err++; $display("FAIL to_resp: bresp %b s_bready %b want 10 0", m0_if.bresp, s_if.bready);
                end
            end
            master_step(b0, b1, r0, r1, rd0, rd1);
        end
        n_cmp++; if (first_at != 16) begin n_err++; $display("FAIL to_delay: bvalid at %0d want 16", first_at); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle: busy %b want 0", busy); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wr_then_rd();
        test_w_before_aw();
        test_reset_mid_read();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
